// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// One DATA_VALID pulse per frame, then waits for Busy to clear; a watchdog drops unacknowledged bytes.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic                          i_tx_busy,
    output logic [DATA_WIDTH-1:0]         o_tx_data,
    output logic                          o_tx_valid,
    output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
    output logic                          o_active,
    output logic                          o_timeout_err
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    state_t                r_state;
    logic [PTR_W-1:0]      r_rr_ptr;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_valid;
    logic [NUM_REQ-1:0]    r_req_ready;
    logic [PTR_W-1:0]      r_grant_id;
    logic                  r_active;
    logic                  r_timeout_err;

    logic                  w_found;
    logic [PTR_W-1:0]      w_winner;
    logic [DATA_WIDTH-1:0] w_win_data;
    logic [NUM_REQ-1:0]    w_onehot;
    logic [PTR_W-1:0]      w_next_ptr;

    // Requester index rr_ptr+off, wrapped modulo NUM_REQ (non-power-of-two safe).
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= int'(NUM_REQ)) begin
            sum = sum - int'(NUM_REQ);
        end
        return PTR_W'(sum);
    endfunction

    // First valid requester at or above rr_ptr, cyclically, and its byte.
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_win_data = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (!w_found && i_req_valid[wrap_idx(r_rr_ptr, k)]) begin
                w_found  = 1'b1;
                w_winner = wrap_idx(r_rr_ptr, k);
            end
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_winner == PTR_W'(i)) begin
                w_win_data = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_onehot   = NUM_REQ'(1) << w_winner;
    assign w_next_ptr = (r_grant_id == PTR_W'(NUM_REQ - 1)) ? '0 : r_grant_id + PTR_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_cnt         <= '0;
            r_tx_data     <= '0;
            r_tx_valid    <= 1'b0;
            r_req_ready   <= '0;
            r_grant_id    <= '0;
            r_active      <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_req_ready   <= '0;
            r_tx_valid    <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found && !i_tx_busy) begin
                        r_req_ready <= w_onehot;
                        r_tx_data   <= w_win_data;
                        r_grant_id  <= w_winner;
                        r_active    <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_tx_valid <= 1'b1;
                    r_cnt      <= '0;
                    r_state    <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    // Acknowledgement takes priority over an expiring watchdog.
                    if (i_tx_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_cnt == CNT_W'(ACK_TIMEOUT)) begin
                        r_timeout_err <= 1'b1;
                        r_rr_ptr      <= w_next_ptr;
                        r_active      <= 1'b0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        r_rr_ptr <= w_next_ptr;
                        r_active <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_active <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_tx_data     = r_tx_data;
    assign o_tx_valid    = r_tx_valid;
    assign o_grant_id    = r_grant_id;
    assign o_active      = r_active;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares a single UART transmitter between `NUM_REQ` byte sources. It sits between the requesters and the UART TX top-level. It accepts one byte at a time from the winning requester, presents it to the transmitter as a single-cycle `DATA_VALID` pulse, then tracks the transmitter's `Busy` until the frame has fully left the line. A watchdog recovers the arbiter if the transmitter never acknowledges a byte.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `DATA_WIDTH`, 8: byte width; matches the UART TX `P_DATA` width.
- `ACK_TIMEOUT`, 15: cycles to wait in WAIT_ACK for `tx_busy` to rise; legal range 3..255.
- `CLK` input 1: single clock; shared with the UART TX.
- `RST` input 1: synchronous, active-high reset. This is the already-decided reset: one clock, synchronous, active-high.
- `req_valid` input `NUM_REQ`: bit i set means requester i holds a byte; held until accepted.
- `req_data` input `NUM_REQ*DATA_WIDTH`: requester i's byte is at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready` output `NUM_REQ`: one-hot, one-cycle accept pulse to the winning requester.
- `tx_busy` input 1: `Busy` from the UART TX.
- `tx_data` output `DATA_WIDTH`: `P_DATA` to the UART TX; holds the latched byte until the next grant.
- `tx_valid` output 1: `DATA_VALID` to the UART TX; one-cycle pulse.
- `grant_id` output `$clog2(NUM_REQ)`: index of the requester currently owning the TX.
- `active` output 1: high in every state except IDLE.
- `timeout_err` output 1: one-cycle pulse when the ACK_TIMEOUT expires.

## Operation
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- **IDLE**
  - If `|req_valid` and `!tx_busy`, select the winner by round-robin.
  - Round-robin search starts at `rr_ptr` and proceeds upward, wrapping modulo NUM_REQ.
  - In the same cycle: assert `req_ready[winner]`, latch `req_data[winner]` into `tx_data`, latch `grant_id=winner`, and go to ISSUE.
  - If `tx_busy`=1 in IDLE, no grant is made; requests wait.
- **ISSUE**
  - Assert `tx_valid`=1 for exactly this cycle, clear the watchdog counter, and go to WAIT_ACK.
- **WAIT_ACK**
  - If `tx_busy`=1, go to WAIT_DONE.
  - Otherwise increment the counter.
  - When the counter reaches ACK_TIMEOUT: pulse `timeout_err`, set `rr_ptr=grant_id+1`, and go to IDLE. The byte is dropped and never re-offered.
- **WAIT_DONE**
  - When `tx_busy`=0, set `rr_ptr=(grant_id+1) mod NUM_REQ` and go to IDLE.
- Exactly one `tx_valid` is issued per frame. The transmitter's back-to-back STOP→START path is never used; every frame returns the TX to its IDLE.
- `req_data` is sampled only in the accept cycle. Later changes by the requester do not affect `tx_data`.
- A `req_valid` that drops before acceptance is simply ignored.
- `rr_ptr` is `$clog2(NUM_REQ)` bits wide. Wrap is explicit modulo NUM_REQ, correct for non-power-of-two NUM_REQ.

## Timing
- Reset values (the cycle after `RST`=1 is sampled):
  - state=IDLE, `rr_ptr`=0, counter=0.
  - `tx_data`=0, `tx_valid`=0, `req_ready`=0, `grant_id`=0, `active`=0, `timeout_err`=0.
- Reset mid-frame aborts immediately, including during WAIT_DONE. Any in-flight byte is lost, and no `req_ready` or `tx_valid` follows.
- Cycle latency:
  - Accept (`req_ready`) at cycle N; `tx_valid` at N+1.
  - The TX registers `Busy` at N+3, so WAIT_ACK normally lasts 2 cycles.
  - End of frame: `tx_busy` falls at cycle M; the arbiter is in IDLE at M+1 and can accept again at M+1.
- `req_ready`, `tx_valid` and `timeout_err` are registered outputs, one cycle wide, and never overlap.
- Simultaneous requests: the winner is the first set bit at or above `rr_ptr`, cyclically. No requester is granted twice while another valid requester is waiting.
- `tx_busy` arriving high in the same cycle the counter hits ACK_TIMEOUT: the acknowledgement wins. Go to WAIT_DONE with no `timeout_err`.

## Test plan
- **Reset:** hold `RST`=1 for 3 cycles with `req_valid`=4'b1111.
  - All outputs stay 0; no `req_ready` during reset.
  - First grant after release goes to requester 0.
- **Single byte:** `req_valid`=4'b0100, byte 0xA5; TX model raises busy 2 cycles after `tx_valid` and holds it 11 cycles.
  - `req_ready`=4'b0100 at N; `tx_valid`=1 with `tx_data`=0xA5 at N+1.
  - `active` stays high until the cycle after busy falls; exactly one frame.
- **Fairness:** hold `req_valid`=4'b1111 with bytes 0x10..0x13.
  - Grant order is 0,1,2,3,0.
  - Each `tx_valid` follows only after the previous busy fell.
- **Wrap / non-power-of-two:** NUM_REQ=3, start `rr_ptr` at 2, `req_valid`=3'b011.
  - Grants go to 0 then 1; never index 3.
- **Timeout:** TX model never raises busy, ACK_TIMEOUT=15.
  - `timeout_err` pulses once, 16 cycles after `tx_valid`.
  - Arbiter returns to IDLE; next grant goes to the next requester.
  - Coincident busy at the limit cycle gives no error.
- **Busy gating and mid-frame reset:**
  - Requests while `tx_busy`=1 in IDLE are not granted.
  - `RST` pulsed during WAIT_DONE clears all outputs; `rr_ptr` returns to 0.
